uart_tx: RTL
============

# uart_tx

Serial transmitter for 8N1 asynchronous frames. It accepts a byte through a single-cycle `send` strobe and shifts it out on `tx`: start bit, eight data bits LSB-first, then stop bit, each bit held for `BAUD_DIV` clocks. It is the sending end of the lab's serial link and drives the board's UART TX pin from the same single-clock, synchronous-clear register fabric as the rest of the design.

## Interface

- `BAUD_DIV`, default 5208: clocks per bit (50 MHz / 9600 baud); legal range ≥ 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `clr`  input  1  synchronous, active-high reset.
- `send`  input  1  transmit request; sampled only when idle.
- `din`  input  8  byte to transmit; captured on the edge that accepts `send`.
- `tx`  output  1  serial line, registered; idles high.
- `busy`  output  1  registered; high while a frame is in progress.

## Operation

- States: IDLE, START, DATA, STOP. Internal registers: 8-bit shift register, 3-bit bit index, baud counter of width ceil(log2(BAUD_DIV)) that counts 0..BAUD_DIV-1.
- IDLE: `tx`=1 and `busy`=0. On an edge with `send`=1:
  - latch `din` into the shift register;
  - clear the baud counter;
  - go to START with `tx`=0 and `busy`=1.
- START: hold `tx`=0. When the baud counter reaches BAUD_DIV-1, clear it, go to DATA, drive `tx`=shift[0], and set the bit index to 0.
- DATA: hold the current bit. At baud terminal count:
  - if the bit index < 7: shift right, increment the index, drive the next bit;
  - if the bit index = 7: go to STOP with `tx`=1.
- STOP: hold `tx`=1. At baud terminal count, go to IDLE and drop `busy` to 0.
- `send` while `busy`=1 is ignored: no queueing and no latching of `din`. Changes to `din` after acceptance do not affect the frame in flight.
- `clr`=1 has priority over everything, including mid-frame. On the next edge:
  - state IDLE, `tx`=1, `busy`=0;
  - all counters and the shift register cleared.
  
  A frame cut off by `clr` is abandoned and never resumed. `send` asserted in the same cycle as `clr` is dropped.
- Reset values: `tx`=1, `busy`=0.

## Timing

- Acceptance edge E: `tx` falls and `busy` rises, both visible right after E. There are no combinational paths from inputs to outputs.
- The start bit occupies edges E..E+BAUD_DIV. Data bit n is driven from edge E+(n+1)·BAUD_DIV. The stop bit starts at E+9·BAUD_DIV.
- `busy` falls at edge E+10·BAUD_DIV, so each frame lasts exactly 10·BAUD_DIV clocks of `busy`=1.
- The earliest next acceptance is edge E+10·BAUD_DIV+1, because `send` is only sampled in IDLE. The back-to-back frame period is therefore 10·BAUD_DIV+1 clocks, and the line is high for BAUD_DIV+1 clocks between frames.
- `send` held high continuously produces frames repeatedly at that period, each carrying the `din` present on its acceptance edge.
- Bit boundaries are exact: no jitter, no drift.

## Test plan

Run all scenarios with `BAUD_DIV`=4.

- **Reset values:** `clr`=1 for 3 cycles, then released with `send`=0 → `tx`=1 and `busy`=0 on every cycle; no transitions on `tx`.
- **Single frame:** `din`=8'hA5 with a one-cycle `send` → sampling `tx` every 4 clocks from the acceptance edge gives 0,1,0,1,0,0,1,0,1,1. `busy` is high for exactly 40 clocks.
- **Ignored request and `din` change:** pulse `send` with `din`=8'h3C at clock 15 of an 8'h5A frame, and change `din` mid-frame → the transmitted bits stay 0,0,1,0,1,1,0,1,0,1; no second frame follows.
- **Back-to-back:** hold `send`=1 with `din`=8'hFF, then switch to `din`=8'h00 during the first frame → two frames with acceptance edges 41 clocks apart. The second frame's data bits are all 0, and the idle-high gap between frames is 5 clocks.
- **Mid-frame reset:** assert `clr` for 1 cycle during data bit 3 of 8'h0F → `tx`=1 and `busy`=0 after that edge and stay so. A new `send` with 8'h81 afterwards yields a clean, complete frame.
- **Simultaneous `clr` and `send`:** assert both on the same edge while idle → no frame starts, and `busy` remains 0.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter, one byte per send strobe
module uart_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          tx_n, busy_n;
  logic          tc;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      cnt   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      tx    <= tx_n;
      busy  <= busy_n;
    end
  end

  // Outputs are computed here and registered above, so tx/busy never see inputs combinationally.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    cnt_n   = cnt;
    tx_n    = tx;
    busy_n  = busy;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (send) begin
          shift_n = din;
          cnt_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tc) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
          idx_n   = 3'd0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (tc) begin
          cnt_n = '0;
          if (idx != 3'd7) begin
            shift_n = {1'b0, shift[7:1]};
            idx_n   = idx + 3'd1;
            tx_n    = shift[1];
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (tc) begin
          cnt_n   = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
